// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and helpers for the Enigma rotor datapath.
// Rotor indices in packed arrays: [2]=left, [1]=middle, [0]=right.
package enigma_pkg;

    localparam logic [2:0] ROTOR_I    = 3'd0;
    localparam logic [2:0] ROTOR_II   = 3'd1;
    localparam logic [2:0] ROTOR_III  = 3'd2;
    localparam logic [2:0] ROTOR_IV   = 3'd3;
    localparam logic [2:0] ROTOR_V    = 3'd4;
    localparam logic [2:0] ROTOR_VI   = 3'd5;
    localparam logic [2:0] ROTOR_VII  = 3'd6;
    localparam logic [2:0] ROTOR_VIII = 3'd7;

    localparam logic [4:0] LETTER_A    = 5'd0;
    localparam logic [4:0] LETTER_Z    = 5'd25;
    localparam int         NUM_LETTERS = 26;

    localparam logic [4:0] NOTCH_I   = 5'd16;
    localparam logic [4:0] NOTCH_II  = 5'd4;
    localparam logic [4:0] NOTCH_III = 5'd21;
    localparam logic [4:0] NOTCH_IV  = 5'd9;
    localparam logic [4:0] NOTCH_V   = 5'd25;
    // VI..VIII carry on both of these letters
    localparam logic [4:0] NOTCH_HI  = 5'd25;
    localparam logic [4:0] NOTCH_LO  = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2
    } step_state_e;

    function automatic logic [4:0] pos_inc(input logic [4:0] p);
        return (p >= LETTER_Z) ? LETTER_A : p + 5'd1;
    endfunction

    function automatic logic pos_valid(input logic [4:0] p);
        return p <= LETTER_Z;
    endfunction

endpackage

// File: rtl/enigma_notch_decode.sv
// Combinational notch detector: is this rotor sitting on a carry letter?
module enigma_notch_decode
    import enigma_pkg::*;
(
    input  logic [4:0] pos_i,
    input  logic [2:0] type_i,
    output logic       at_notch_o
);

    always_comb begin
        at_notch_o = 1'b0;
        case (type_i)
            ROTOR_I:   at_notch_o = (pos_i == NOTCH_I);
            ROTOR_II:  at_notch_o = (pos_i == NOTCH_II);
            ROTOR_III: at_notch_o = (pos_i == NOTCH_III);
            ROTOR_IV:  at_notch_o = (pos_i == NOTCH_IV);
            ROTOR_V:   at_notch_o = (pos_i == NOTCH_V);
            default:   at_notch_o = (pos_i == NOTCH_HI) || (pos_i == NOTCH_LO);
        endcase
    end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Rotor stepping controller: holds positions/types and applies the ratchet
// rules (including the middle-rotor double step) once per accepted keypress.
module enigma_step_ctrl
    import enigma_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_load,
    input  logic [2:0] cfg_type_l,
    input  logic [2:0] cfg_type_m,
    input  logic [2:0] cfg_type_r,
    input  logic [4:0] cfg_pos_l,
    input  logic [4:0] cfg_pos_m,
    input  logic [4:0] cfg_pos_r,
    input  logic       step_req,
    output logic       step_busy,
    output logic       step_done,
    output logic [2:0] stepped_mask,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    output logic [2:0] type_l,
    output logic [2:0] type_m,
    output logic [2:0] type_r,
    output logic       cfg_err,
    output logic       step_ovf
);

    step_state_e state_q, state_d;

    logic [2:0][4:0] pos_q, pos_d;
    logic [2:0][2:0] type_q, type_d;
    logic [2:0]      notch_q, notch_d;
    logic [2:0]      mask_q, mask_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;

    logic [2:0]      at_notch;
    logic [2:0][4:0] cfg_pos;
    logic [2:0][2:0] cfg_type;
    logic            step_acc;
    logic            cfg_take;
    logic            cfg_ok;

    assign cfg_pos  = {cfg_pos_l, cfg_pos_m, cfg_pos_r};
    assign cfg_type = {cfg_type_l, cfg_type_m, cfg_type_r};

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_notch
            enigma_notch_decode u_dec (
                .pos_i      (pos_q[g]),
                .type_i     (type_q[g]),
                .at_notch_o (at_notch[g])
            );
        end
    endgenerate

    assign cfg_take = (state_q == ST_IDLE) && cfg_load;
    assign cfg_ok   = pos_valid(cfg_pos_l) && pos_valid(cfg_pos_m) && pos_valid(cfg_pos_r);
    assign step_acc = (state_q == ST_IDLE) && step_req && !cfg_load;

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (step_acc) state_d = ST_EVAL;
            ST_EVAL:   state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_COMMIT);
        err_d   = cfg_take && !cfg_ok;
        pos_d   = pos_q;
        type_d  = type_q;
        notch_d = notch_q;
        mask_d  = mask_q;

        // A dropped keypress outranks the clear from a simultaneous good load
        ovf_d = ovf_q;
        if (cfg_take && cfg_ok)                           ovf_d = 1'b0;
        if (step_req && (state_q != ST_IDLE || cfg_load)) ovf_d = 1'b1;

        if (cfg_take && cfg_ok) begin
            pos_d  = cfg_pos;
            type_d = cfg_type;
        end

        if (state_q == ST_EVAL) notch_d = at_notch;

        if (state_q == ST_COMMIT) begin
            pos_d[0] = pos_inc(pos_q[0]);
            if (notch_q[0] || notch_q[1]) pos_d[1] = pos_inc(pos_q[1]);
            if (notch_q[1])               pos_d[2] = pos_inc(pos_q[2]);
            mask_d = {notch_q[1], notch_q[0] | notch_q[1], 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q   <= '0;
            type_q  <= {ROTOR_I, ROTOR_II, ROTOR_III};
            notch_q <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            type_q  <= type_d;
            notch_q <= notch_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pos_l        = pos_q[2];
    assign pos_m        = pos_q[1];
    assign pos_r        = pos_q[0];
    assign type_l       = type_q[2];
    assign type_m       = type_q[1];
    assign type_r       = type_q[0];
    assign stepped_mask = mask_q;
    assign step_busy    = busy_q;
    assign step_done    = done_q;
    assign cfg_err      = err_q;
    assign step_ovf     = ovf_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Scoreboard bench: a letter-level Enigma stepping model predicts each
// step_done result; a monitor pops and compares whenever step_done fires.
module tb_enigma_step_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_load = 1'b0;
    logic [2:0] cfg_type_l = '0, cfg_type_m = '0, cfg_type_r = '0;
    logic [4:0] cfg_pos_l = '0, cfg_pos_m = '0, cfg_pos_r = '0;
    logic       step_req = 1'b0;
    logic       step_busy, step_done, cfg_err, step_ovf;
    logic [2:0] stepped_mask, type_l, type_m, type_r;
    logic [4:0] pos_l, pos_m, pos_r;

    enigma_step_ctrl dut (
        .clock(clock), .reset(reset), .cfg_load(cfg_load),
        .cfg_type_l(cfg_type_l), .cfg_type_m(cfg_type_m), .cfg_type_r(cfg_type_r),
        .cfg_pos_l(cfg_pos_l), .cfg_pos_m(cfg_pos_m), .cfg_pos_r(cfg_pos_r),
        .step_req(step_req), .step_busy(step_busy), .step_done(step_done),
        .stepped_mask(stepped_mask), .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .type_l(type_l), .type_m(type_m), .type_r(type_r),
        .cfg_err(cfg_err), .step_ovf(step_ovf)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    // Reference model: index 0=left, 1=middle, 2=right
    int    m_pos[3];
    int    m_type[3];
    bit    m_ovf;
    string notch1 = "QEVJZ";
    logic [17:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit at_notch(input int t, input int p);
        if (t < 5) return p == (int'(notch1[t]) - 65);
        return (p == 25) || (p == 12);
    endfunction

    task automatic model_reset();
        m_pos  = '{0, 0, 0};
        m_type = '{0, 1, 2};
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        bit nr, nm, sl, sm;
        nr = at_notch(m_type[2], m_pos[2]);
        nm = at_notch(m_type[1], m_pos[1]);
        sl = nm;
        sm = nr || nm;
        m_pos[2] = (m_pos[2] + 1) % 26;
        if (sm) m_pos[1] = (m_pos[1] + 1) % 26;
        if (sl) m_pos[0] = (m_pos[0] + 1) % 26;
        exp_q.push_back({5'(m_pos[0]), 5'(m_pos[1]), 5'(m_pos[2]), sl, sm, 1'b1});
    endtask

    always @(negedge clock) begin
        if (!reset && step_done) begin
            logic [17:0] e;
            n_done++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got pos %0d/%0d/%0d with nothing expected",
                         pos_l, pos_m, pos_r);
            end else begin
                e = exp_q.pop_front();
                if ({pos_l, pos_m, pos_r, stepped_mask} != e) begin
                    n_fail++;
                    $display("FAIL step_result: got %0d/%0d/%0d mask %b expected %0d/%0d/%0d mask %b",
                             pos_l, pos_m, pos_r, stepped_mask,
                             e[17:13], e[12:8], e[7:3], e[2:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string name);
        chk({name, "_pos_l"}, int'(pos_l), m_pos[0]);
        chk({name, "_pos_m"}, int'(pos_m), m_pos[1]);
        chk({name, "_pos_r"}, int'(pos_r), m_pos[2]);
        chk({name, "_type"}, int'({type_l, type_m, type_r}),
            int'({3'(m_type[0]), 3'(m_type[1]), 3'(m_type[2])}));
        chk({name, "_ovf"}, int'(step_ovf), int'(m_ovf));
    endtask

    task automatic do_step(input string name, input bit drop, input bit check_mask,
                           input int exp_mask);
        model_step();
        step_req = 1'b1;
        tick();
        chk({name, "_busy1"}, int'(step_busy), 1);
        chk({name, "_done1"}, int'(step_done), 0);
        step_req = drop;
        if (drop) m_ovf = 1'b1;
        tick();
        step_req = 1'b0;
        chk({name, "_busy2"}, int'(step_busy), 1);
        tick();
        chk({name, "_done3"}, int'(step_done), 1);
        chk({name, "_busy3"}, int'(step_busy), 0);
        if (check_mask) chk({name, "_mask"}, int'(stepped_mask), exp_mask);
        chk_state(name);
    endtask

    task automatic do_cfg(input string name, input int tl, input int tm, input int tr,
                          input int pl, input int pm, input int pr, input bit with_step);
        bit ok;
        cfg_type_l = 3'(tl); cfg_type_m = 3'(tm); cfg_type_r = 3'(tr);
        cfg_pos_l  = 5'(pl); cfg_pos_m  = 5'(pm); cfg_pos_r  = 5'(pr);
        cfg_load = 1'b1;
        step_req = with_step;
        ok = (pl <= 25) && (pm <= 25) && (pr <= 25);
        if (ok) begin
            m_type = '{tl, tm, tr};
            m_pos  = '{pl, pm, pr};
            m_ovf  = 1'b0;
        end
        if (with_step) m_ovf = 1'b1;
        tick();
        cfg_load = 1'b0;
        step_req = 1'b0;
        chk({name, "_cfg_err"}, int'(cfg_err), int'(!ok));
        chk({name, "_busy"}, int'(step_busy), 0);
        chk_state(name);
        tick();
        chk({name, "_cfg_err_clr"}, int'(cfg_err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_state("reset");
        chk("reset_busy", int'(step_busy), 0);
        chk("reset_done", int'(step_done), 0);
        chk("reset_mask", int'(stepped_mask), 0);
        chk("reset_err",  int'(cfg_err), 0);

        do_step("first", 1'b0, 1'b1, 3'b001);

        // Double step ADU -> ADV -> AEW -> BFX
        do_cfg("ds_cfg", 0, 1, 2, 0, 3, 20, 1'b0);
        do_step("ds1", 1'b0, 1'b1, 3'b001);
        do_step("ds2", 1'b0, 1'b1, 3'b011);
        do_step("ds3", 1'b0, 1'b1, 3'b111);

        do_cfg("wrap_cfg", 4, 4, 4, 25, 25, 25, 1'b0);
        do_step("wrap", 1'b0, 1'b1, 3'b111);

        do_cfg("dual_cfg", 0, 0, 5, 0, 0, 12, 1'b0);
        do_step("dual_m", 1'b0, 1'b1, 3'b011);
        do_cfg("dual_cfg2", 0, 0, 5, 0, 0, 25, 1'b0);
        do_step("dual_z", 1'b0, 1'b1, 3'b011);

        // Rejected load keeps everything, including stepped_mask
        do_cfg("bad_r", 7, 7, 7, 1, 2, 26, 1'b0);
        chk("bad_r_mask_kept", int'(stepped_mask), 3'b011);

        do_cfg("cfg_and_step", 2, 3, 4, 5, 6, 7, 1'b1);
        tick(); tick();
        chk("cfg_and_step_no_step", int'(pos_r), 7);

        do_cfg("ovf_clr", 2, 3, 4, 5, 6, 7, 1'b0);
        do_step("drop", 1'b1, 1'b0, 0);
        tick(); tick(); tick();
        do_cfg("drop_clr", 0, 1, 2, 8, 9, 10, 1'b0);

        // Reset during COMMIT: no step_done, everything back to reset values
        saved = n_done;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        tick(); tick(); tick();
        chk("rst_mid_no_done", n_done, saved);
        chk_state("rst_mid");
        chk("rst_mid_mask", int'(stepped_mask), 0);
        chk("rst_mid_busy", int'(step_busy), 0);

        // Randomised loads, steps and busy drops
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p[3];
                for (int k = 0; k < 3; k++) p[k] = $urandom_range(0, 25);
                if ($urandom_range(0, 4) == 0) p[$urandom_range(0, 2)] = $urandom_range(26, 31);
                do_cfg("rnd_cfg", $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), p[0], p[1], p[2], $urandom_range(0, 5) == 0);
            end else begin
                do_step("rnd_step", $urandom_range(0, 5) == 0, 1'b0, 0);
            end
        end

        tick(); tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
